pwm_sample_scheduler: RTL and testbench

Sequencer that streams duty-cycle samples into the PWM DAC. Samples arrive over a valid/ready handshake into a small FIFO. The block generates the DAC's `enable` tick and its `count_value`. At each PWM period boundary it loads the next sample as the new duty cycle, so the duty cycle never changes mid-period. It sits between the sample source (tone/waveform generator) and the PWM DAC. Its outputs connect directly to the DAC's `enable`, `duty_cycle` and `count_value` inputs, and the DAC shares the same `clk` and `reset_n`.

---
 rtl/pwm_sample_scheduler_if.sv | 20 ++
 rtl/pwm_sample_scheduler.sv | 170 +++++++++++++++++
 tb/tb_pwm_sample_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sample_scheduler_if.sv
// Sample stream handshake between the waveform source and the PWM sample scheduler.
interface pwm_sample_scheduler_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/pwm_sample_scheduler.sv
// PWM sample scheduler: buffers duty samples in a small FIFO and loads one into
// the PWM DAC at each period boundary, generating the DAC enable tick and count.
// Optional feature: define PWM_SCHED_HOLD_LAST_EN to hold the last duty on
// underrun instead of driving midscale.
module pwm_sample_scheduler #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [WIDTH-1:0]         period,
    pwm_sample_scheduler_if.slave    sample_bus,
    output logic                     pwm_enable,
    output logic [WIDTH-1:0]         pwm_duty,
    output logic [WIDTH-1:0]         pwm_count,
    output logic                     period_start,
    output logic                     underrun,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_COUNT = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        STOPPING
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] phase;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             running;
    logic             tick;
    logic             boundary;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign head     = mem[rd_ptr];
    assign push     = sample_bus.sample_valid && !full;
    assign running  = (state == RUN) || (state == STOPPING);
    assign tick     = running && (presc == PRE_LAST);
    assign boundary = tick && (phase == pwm_count);

    // A stop in PRIME wins over a pending first load.
    assign pop = !empty &&
                 (((state == PRIME) && !stop) || ((state == RUN) && boundary));

    assign sample_bus.sample_ready = !full;
    assign pwm_enable              = tick;
    assign busy                    = (state != IDLE);

    // FIFO storage; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_bus.sample_data;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave level unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Prescaler and phase counter, mirroring the DAC counter while running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= '0;
        end else if (!running) begin
            // Phase is already 0 whenever the block leaves RUN/STOPPING, so
            // holding both cleared outside them equals clearing on start.
            presc <= '0;
            phase <= '0;
        end else if (tick) begin
            presc <= '0;
            phase <= (phase == pwm_count) ? '0 : phase + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Sequencer FSM with registered duty, count and event pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pwm_duty     <= '0;
            pwm_count    <= '0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            period_start <= 1'b0;
            underrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pwm_count <= (period == '0) ? MIN_COUNT : period;
                        state     <= PRIME;
                    end
                end
                PRIME: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!empty) begin
                        pwm_duty     <= head;
                        period_start <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (!empty) begin
                            pwm_duty     <= head;
                            period_start <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
`ifdef PWM_SCHED_HOLD_LAST_EN
                            pwm_duty <= pwm_duty;
`else
                            pwm_duty <= MIDSCALE;
`endif
                        end
                    end
                    if (stop) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (boundary) begin
                        pwm_duty <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Self-checking bench for pwm_sample_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pwm_sample_scheduler;
    localparam int W    = 9;
    localparam int D    = 4;
    localparam int PRE1 = 1;
`ifdef PWM_SCHED_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with PRESCALE=1
    logic         reset_n, start, stop;
    logic [W-1:0] period;
    logic         pwm_enable, period_start, underrun, busy;
    logic [W-1:0] pwm_duty, pwm_count;
    logic [$clog2(D):0] level;
    pwm_sample_scheduler_if #(.WIDTH(W)) sbus ();

    pwm_sample_scheduler #(.WIDTH(W), .DEPTH(D), .PRESCALE(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period(period),
        .sample_bus(sbus), .pwm_enable(pwm_enable), .pwm_duty(pwm_duty),
        .pwm_count(pwm_count), .period_start(period_start), .underrun(underrun),
        .busy(busy), .level(level)
    );

    // Instance with PRESCALE=3
    logic         start3, stop3;
    logic [W-1:0] period3;
    logic         pwm_enable3, period_start3, underrun3, busy3;
    logic [W-1:0] pwm_duty3, pwm_count3;
    logic [$clog2(D):0] level3;
    pwm_sample_scheduler_if #(.WIDTH(W)) sbus3 ();

    pwm_sample_scheduler #(.WIDTH(W), .DEPTH(D), .PRESCALE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .stop(stop3), .period(period3),
        .sample_bus(sbus3), .pwm_enable(pwm_enable3), .pwm_duty(pwm_duty3),
        .pwm_count(pwm_count3), .period_start(period_start3), .underrun(underrun3),
        .busy(busy3), .level(level3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_evt = 0;

    // Reference model: FIFO as a queue, time measured in clocks since RUN entry
    int q[$];
    int m_mode;   // 0 idle, 1 waiting for first sample, 2 running, 3 draining
    int m_t;
    int m_duty, m_cnt;
    bit m_ps, m_ur;
    int dac;      // DAC counter driven by the DUT's enable/count outputs

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int plen;
        bit bnd;
        bit pushing;
        if (!reset_n) dac = 0;
        else if (pwm_enable) dac = (dac == int'(pwm_count)) ? 0 : dac + 1;
        if (!reset_n) begin
            q.delete();
            m_mode = 0; m_t = 0; m_duty = 0; m_cnt = 0; m_ps = 0; m_ur = 0;
            return;
        end
        pushing = sbus.sample_valid && (q.size() < D);
        plen = (m_cnt + 1) * PRE1;
        bnd  = (m_mode >= 2) && ((m_t % plen) == plen - 1);
        m_ps = 0;
        m_ur = 0;
        case (m_mode)
            0: if (start) begin
                m_cnt  = (period == 0) ? 1 : int'(period);
                m_mode = 1;
                m_t    = 0;
            end
            1: if (stop) m_mode = 0;
               else if (q.size() > 0) begin
                   m_duty = q.pop_front(); m_ps = 1; m_mode = 2; m_t = 0;
               end
            2: begin
                if (bnd) begin
                    if (q.size() > 0) begin
                        m_duty = q.pop_front(); m_ps = 1;
                    end else begin
                        m_ur = 1;
                        m_duty = HOLD ? m_duty : (1 << (W - 1));
                    end
                end
                if (stop) m_mode = 3;
                m_t++;
            end
            default: if (bnd) begin
                m_duty = 0; m_mode = 0; m_t = 0;
            end else m_t++;
        endcase
        if (pushing) q.push_back(int'(sbus.sample_data));
    endtask

    task automatic check_model();
        chk("duty", pwm_duty, m_duty);
        chk("count", pwm_count, m_cnt);
        chk("period_start", period_start, m_ps);
        chk("underrun", underrun, m_ur);
        chk("enable", pwm_enable, (m_mode >= 2) && ((m_t % PRE1) == PRE1 - 1));
        chk("busy", busy, m_mode != 0);
        chk("level", level, q.size());
        chk("ready", sbus.sample_ready, q.size() < D);
        if (m_mode == 0) chk("dac_idle", dac, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic wait_pulse(input string name, input bit want_ur, input int gap, input int duty);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(want_ur ? underrun : period_start) && n < 100);
        chk({name, "_seen"}, want_ur ? underrun : period_start, 1);
        chk({name, "_gap"}, cyc - last_evt, gap);
        chk({name, "_duty"}, pwm_duty, duty);
        last_evt = cyc;
    endtask

    task automatic wait_dac(input int val);
        int n = 0;
        while (dac != val && n < 50) begin
            step();
            n++;
        end
        chk("dac_reach", dac, val);
    endtask

    typedef struct {
        bit start;
        bit valid;
        int data;
        int per;
        int e_level;
        bit e_ready;
        bit e_busy;
        int e_duty;
        bit e_ps;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n;
        // FIFO fill past full, then start: first load two edges after start
        tbl[0] = '{0, 1, 10, 9, 1, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 20, 9, 2, 1, 0, 0, 0};
        tbl[2] = '{0, 1, 30, 9, 3, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 40, 9, 4, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 50, 9, 4, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 50, 9, 4, 0, 1, 0, 0};
        tbl[6] = '{0, 1, 50, 9, 3, 1, 1, 10, 1};
        tbl[7] = '{0, 1, 50, 9, 4, 0, 1, 10, 0};
        tbl[8] = '{0, 0, 0, 9, 4, 0, 1, 10, 0};

        reset_n = 0; start = 0; stop = 0; period = '0;
        sbus.sample_valid = 0; sbus.sample_data = '0;
        start3 = 0; stop3 = 0; period3 = '0;
        sbus3.sample_valid = 0; sbus3.sample_data = '0;
        step();
        step();
        chk("rst_ready", sbus.sample_ready, 1);
        chk("rst_duty", pwm_duty, 0);
        chk("rst_count", pwm_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        reset_n = 1;

        for (int i = 0; i < 9; i++) begin
            start             = tbl[i].start;
            sbus.sample_valid = tbl[i].valid;
            sbus.sample_data  = W'(tbl[i].data);
            period            = W'(tbl[i].per);
            step();
            chk("tbl_level", level, tbl[i].e_level);
            chk("tbl_ready", sbus.sample_ready, tbl[i].e_ready);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_duty", pwm_duty, tbl[i].e_duty);
            chk("tbl_period_start", period_start, tbl[i].e_ps);
            if (tbl[i].e_ps) last_evt = cyc;
        end
        start = 0;
        sbus.sample_valid = 0;

        // Basic run: one load per 10 clocks, then underrun once FIFO drains
        wait_pulse("load20", 0, 10, 20);
        wait_pulse("load30", 0, 10, 30);
        wait_pulse("load40", 0, 10, 40);
        wait_pulse("load50", 0, 10, 50);
        wait_pulse("underrun", 1, 10, HOLD ? 50 : 256);

        // Stop at phase 4: busy holds until the boundary, then clean idle
        wait_dac(4);
        stop = 1;
        step();
        stop = 0;
        n = 1;
        chk("stop_busy_hold", busy, 1);
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("stop_steps", n, 6);
        chk("stop_busy", busy, 0);
        chk("stop_duty", pwm_duty, 0);
        chk("stop_enable", pwm_enable, 0);
        chk("stop_dac", dac, 0);

        // PRESCALE=3 with period 0: count clamps to 1, tick every 3, boundary every 6
        sbus3.sample_valid = 1;
        sbus3.sample_data = W'(5); step();
        sbus3.sample_data = W'(6); step();
        sbus3.sample_data = W'(7); step();
        sbus3.sample_valid = 0;
        period3 = '0;
        start3 = 1;
        step();
        start3 = 0;
        chk("p3_count", pwm_count3, 1);
        chk("p3_busy", busy3, 1);
        for (int t = 0; t < 18; t++) begin
            step();
            if (t == 0) chk("p3_first_duty", pwm_duty3, 5);
            chk("p3_enable", pwm_enable3, (t % 3) == 2);
            chk("p3_boundary", period_start3 | underrun3, (t % 6) == 0);
        end
        stop3 = 1;
        step();
        stop3 = 0;
        n = 0;
        while (busy3 && n < 20) begin
            step();
            n++;
        end
        chk("p3_idle", busy3, 0);

        // Reset mid-run at phase 5
        sbus.sample_valid = 1;
        sbus.sample_data = W'(60); step();
        sbus.sample_data = W'(70); step();
        sbus.sample_valid = 0;
        period = W'(9);
        start = 1;
        step();
        start = 0;
        wait_dac(5);
        reset_n = 0;
        step();
        reset_n = 1;
        chk("mrst_level", level, 0);
        chk("mrst_ready", sbus.sample_ready, 1);
        chk("mrst_duty", pwm_duty, 0);
        chk("mrst_count", pwm_count, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_enable", pwm_enable, 0);
        chk("mrst_pulses", period_start | underrun, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            sbus.sample_valid = ($urandom_range(0, 99) < 40);
            sbus.sample_data  = W'($urandom);
            start             = ($urandom_range(0, 99) < 5);
            stop              = ($urandom_range(0, 99) < 2);
            period            = W'($urandom_range(0, 6));
            reset_n           = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
        $fatal(1);
    end
endmodule
